// File: rtl/en_strobe_gen.sv
// en_strobe_gen: programmable clock-enable strobe generator.
// It drives the en input of downstream DFFE banks with one-cycle pulses
// spaced div+1 cycles apart, either continuously (burst=0) or for a counted
// burst. It runs under start/stop control, and all state is in the clk domain.
// Optional build macro: EN_STROBE_AUTORELOAD_EN. When defined, a finished
// burst reloads itself and the generator stays in RUN until stop or reset.
module en_strobe_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst,
    output logic             en,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   pre_reg, pre_next;
    logic [CNT_W-1:0]   rem_reg, rem_next;
    logic [DIV_W-1:0]   div_l_reg, div_l_next;
    logic [CNT_W-1:0]   burst_l_reg, burst_l_next;
    logic               en_reg, en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // State and output registers; reset clears everything at once, mid-burst included.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            pre_reg     <= '0;
            rem_reg     <= '0;
            div_l_reg   <= '0;
            burst_l_reg <= '0;
            en_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            rem_reg     <= rem_next;
            div_l_reg   <= div_l_next;
            burst_l_reg <= burst_l_next;
            en_reg      <= en_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic. en and done default low, so each is a single-cycle pulse.
    always_comb begin
        state_next   = state_reg;
        pre_next     = pre_reg;
        rem_next     = rem_reg;
        div_l_next   = div_l_reg;
        burst_l_next = burst_l_reg;
        en_next      = 1'b0;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                // A simultaneous stop overrides start.
                if (start && !stop) begin
                    div_l_next   = div;
                    burst_l_next = burst;
                    pre_next     = div;
                    rem_next     = burst;
                    state_next   = RUN;
                    busy_next    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort: no final strobe and no done, even on the terminal edge.
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (pre_reg == '0) begin
                    en_next  = 1'b1;
                    pre_next = div_l_reg;
                    if (burst_l_reg != '0) begin
                        rem_next = rem_reg - CNT_W'(1);
                        if (rem_reg == CNT_W'(1)) begin
                            // The terminal strobe and done are coincident.
                            done_next = 1'b1;
`ifdef EN_STROBE_AUTORELOAD_EN
                            rem_next   = burst_l_reg;
`else
                            state_next = IDLE;
                            busy_next  = 1'b0;
`endif
                        end
                    end
                end else begin
                    pre_next = pre_reg - DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign en   = en_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_en_strobe_gen.sv
// tb_en_strobe_gen: self-checking bench for en_strobe_gen.
// The reference model works from the schedule itself: a burst accepted at
// edge s strobes at edges s + n*(div+1). The bench honours
// EN_STROBE_AUTORELOAD_EN in the same way as the design.
module tb_en_strobe_gen;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  burst = '0;
    logic        en, busy, done;

    en_strobe_gen #(.DIV_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .stop  (stop),
        .div   (div),
        .burst (burst),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total_cnt = 0;
    int pass_cnt = 0;

    // Reference model state.
    bit m_active = 0;
    int m_s = 0;
    int m_div = 0;
    int m_burst = 0;
    bit exp_en = 0, exp_busy = 0, exp_done = 0;

    task automatic chk(input string tag, input logic obs, input logic expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
    endtask

    task automatic check_all();
        chk("en", en, exp_en);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
    endtask

    task automatic model_reset();
        m_active = 0;
        exp_en = 0;
        exp_busy = 0;
        exp_done = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int d, n;
        exp_en = 0;
        exp_done = 0;
        if (!clrn) begin
            model_reset();
        end else if (!m_active) begin
            exp_busy = 0;
            if (start && !stop) begin
                m_active = 1;
                m_s = cyc;
                m_div = int'(div);
                m_burst = int'(burst);
                exp_busy = 1;
                $display("cyc %0d: start div=%0d burst=%0d", cyc, m_div, m_burst);
            end
        end else if (stop) begin
            m_active = 0;
            exp_busy = 0;
            $display("cyc %0d: stop", cyc);
        end else begin
            d = cyc - m_s;
            if (d % (m_div + 1) == 0) begin
                n = d / (m_div + 1);
                exp_en = 1;
                if (m_burst != 0 && n == m_burst) begin
                    exp_done = 1;
                    $display("cyc %0d: burst of %0d complete", cyc, m_burst);
`ifdef EN_STROBE_AUTORELOAD_EN
                    m_s = cyc;
`else
                    m_active = 0;
                    exp_busy = 0;
`endif
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic do_start(input int d, input int b);
        div = 16'(d);
        burst = 8'(b);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state.
        model_reset();
        #2;
        check_all();
        step(2);
        clrn = 1'b1;
        step(3);

        // Counted burst: div=3, burst=4.
        do_start(3, 4);
        step(20);

        // Continuous mode with div=0, then stop.
        do_start(0, 0);
        step(10);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);

        // Stop on the terminal-strobe edge (div=2, burst=3 -> terminal 9 edges after start).
        do_start(2, 3);
        step(8);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);

        // start and stop together in IDLE.
        start = 1'b1;
        stop = 1'b1;
        step(3);
        start = 1'b0;
        stop = 1'b0;

        // div changed during RUN is ignored.
        do_start(5, 3);
        div = 16'd1;
        step(22);

        // Asynchronous reset mid-burst.
        do_start(3, 5);
        step(7);
        clrn = 1'b0;
        #1;
        model_reset();
        check_all();
        step(2);
        clrn = 1'b1;
        step(5);

        // Back-to-back bursts with start held high.
        div = 16'd1;
        burst = 8'd2;
        start = 1'b1;
        step(15);
        start = 1'b0;
        stop = 1'b1;
        step(2);
        stop = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(3) == 0);
            stop  = ($urandom_range(15) == 0);
            div   = 16'($urandom_range(4));
            burst = 8'($urandom_range(4));
            step(1);
        end
        start = 1'b0;
        stop = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
